// File: rtl/spi_log_arbiter.sv
// spi_log_arbiter
//
// Captures the first HDR_BYTES bytes of each SPI transaction. Each record is
// optionally prefixed with a free-running timestamp, MSB first. All-zero
// headers can be dropped. Records are serialised onto the UART TX byte
// stream, with a single-byte user command buffer merged in at lower priority.
//
// Handshake: a byte moves to the UART in exactly the cycle where
// uart_txd_strobe=1. The strobe is only raised while uart_txd_ready=1, and
// uart_txd is valid in that same cycle. user_txd_strobe is accepted only while
// user_txd_ready=1; strobes seen at other times are ignored.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   log_enable             allow new transactions to be logged
//   spi_rx_strobe/cmd/data received SPI byte (cmd marks first of transaction)
//   user_txd_strobe/data   user byte in; user_txd_ready = buffer empty
//   uart_txd/_strobe       byte and write strobe to the UART FIFO
//   uart_txd_ready         UART FIFO can take a byte this cycle
//   drop_count/drop_clear  saturating count of lost transactions, and its clear
module spi_log_arbiter #(
  parameter int HDR_BYTES   = 4,
  parameter int TS_BITS     = 16,
  parameter int FILTER_ZERO = 1,
  parameter int DROP_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 log_enable,
  input  logic                 spi_rx_strobe,
  input  logic                 spi_rx_cmd,
  input  logic [7:0]           spi_rx_data,
  input  logic                 user_txd_strobe,
  input  logic [7:0]           user_txd_data,
  output logic                 user_txd_ready,
  output logic [7:0]           uart_txd,
  output logic                 uart_txd_strobe,
  input  logic                 uart_txd_ready,
  output logic [DROP_BITS-1:0] drop_count,
  input  logic                 drop_clear
);

  localparam int TSB       = TS_BITS / 8;
  localparam int REC_BYTES = TSB + HDR_BYTES;
  localparam int TSW       = (TS_BITS > 0) ? TS_BITS : 1;
  localparam int HW        = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
  localparam int EW        = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;

  // CAPTURE corresponds to log_this; PENDING corresponds to rec_pending.
  typedef enum logic [1:0] {
    REC_IDLE    = 2'd0,
    REC_CAPTURE = 2'd1,
    REC_PENDING = 2'd2
  } rec_state_t;

  rec_state_t           state_q, state_d;
  logic [TSW-1:0]       ts_q;
  logic [TSW-1:0]       ts_latch_q;
  logic [7:0]           hdr_q [HDR_BYTES];
  logic [HW-1:0]        idx_q;
  logic [EW-1:0]        emit_q;
  logic                 user_pending_q;
  logic [7:0]           user_byte_q;
  logic [7:0]           uart_txd_q;
  logic [DROP_BITS-1:0] drop_q;

  logic       cmd_stb, cmd_accept, drop_inc, hdr_wr, hdr_last;
  logic       hdr_zero, rec_filtered, rec_active, rec_send, rec_last;
  logic       user_send, tx_send;
  logic [7:0] rec_byte, tx_byte;
  logic [31:0] ts_ext;
  logic [HW-1:0] hsel;
  int         e;

  assign cmd_stb    = spi_rx_strobe && spi_rx_cmd;
  assign cmd_accept = cmd_stb && log_enable && (state_q != REC_PENDING) && uart_txd_ready;
  assign drop_inc   = cmd_stb && log_enable && ((state_q == REC_PENDING) || !uart_txd_ready);
  assign hdr_wr     = spi_rx_strobe && !spi_rx_cmd && (state_q == REC_CAPTURE);
  assign hdr_last   = hdr_wr && (idx_q == HW'(HDR_BYTES - 1));

  always_comb begin
    hdr_zero = 1'b1;
    for (int i = 0; i < HDR_BYTES; i++) begin
      if (hdr_q[i] != 8'h00) hdr_zero = 1'b0;
    end
  end

  // The header is frozen while pending, so the filter result stays stable
  // and the record drops out in its first pending cycle.
  assign rec_filtered = (state_q == REC_PENDING) && (FILTER_ZERO != 0) && hdr_zero;
  assign rec_active   = (state_q == REC_PENDING) && !rec_filtered;
  assign rec_send     = !reset && rec_active && uart_txd_ready;
  assign rec_last     = rec_send && (emit_q == EW'(REC_BYTES - 1));
  // While a record is active, no user byte can be sent, so records are never
  // interleaved with user bytes.
  assign user_send    = !reset && user_pending_q && uart_txd_ready && !rec_active;
  assign tx_send      = rec_send || user_send;

  // Byte select within the record: timestamp bytes MSB first, then header.
  always_comb begin
    e        = int'(emit_q);
    ts_ext   = 32'(ts_latch_q);
    hsel     = HW'(e - TSB);
    rec_byte = 8'(ts_ext >> (8 * (TSB - 1 - e)));
    if (e >= TSB) rec_byte = hdr_q[hsel];
  end

  assign tx_byte = rec_send ? rec_byte : user_byte_q;

  // Record FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      REC_IDLE, REC_CAPTURE: begin
        if (cmd_stb) begin
          // A new command always ends any partial capture; it only starts a
          // fresh one if accepted.
          if (cmd_accept) state_d = (HDR_BYTES == 1) ? REC_PENDING : REC_CAPTURE;
          else            state_d = REC_IDLE;
        end else if (hdr_last) begin
          state_d = REC_PENDING;
        end
      end
      REC_PENDING: begin
        if (rec_filtered || rec_last) state_d = REC_IDLE;
      end
      default: state_d = REC_IDLE;
    endcase
  end

  // Record FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= REC_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q           <= '0;
      idx_q          <= '0;
      emit_q         <= '0;
      user_pending_q <= 1'b0;
      uart_txd_q     <= 8'h00;
      drop_q         <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;

      if (cmd_accept) begin
        hdr_q[0]   <= spi_rx_data;
        ts_latch_q <= ts_q;
        idx_q      <= HW'(1);
      end else if (hdr_wr) begin
        hdr_q[idx_q] <= spi_rx_data;
        idx_q        <= idx_q + 1'b1;
      end

      if (rec_last || rec_filtered) emit_q <= '0;
      else if (rec_send)            emit_q <= emit_q + 1'b1;

      if (user_send) begin
        user_pending_q <= 1'b0;
      end else if (user_txd_strobe && !user_pending_q) begin
        user_pending_q <= 1'b1;
        user_byte_q    <= user_txd_data;
      end

      if (tx_send) uart_txd_q <= tx_byte;

      if (drop_clear)                          drop_q <= '0;
      else if (drop_inc && (drop_q != '1))     drop_q <= drop_q + 1'b1;
    end
  end

  assign uart_txd_strobe = tx_send;
  assign uart_txd        = tx_send ? tx_byte : uart_txd_q;
  assign user_txd_ready  = !user_pending_q;
  assign drop_count      = drop_q;

endmodule

// File: tb/tb_spi_log_arbiter.sv
module tb_spi_log_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic       a_reset = 1'b1, a_log_enable = 1'b1;
  logic       a_spi_stb = 1'b0, a_spi_cmd = 1'b0;
  logic [7:0] a_spi_data = 8'h00;
  logic       a_user_stb = 1'b0;
  logic [7:0] a_user_data = 8'h00;
  logic       a_user_ready;
  logic [7:0] a_uart_txd;
  logic       a_uart_stb;
  logic       a_uart_ready = 1'b1;
  logic [7:0] a_drop;
  logic       a_drop_clear = 1'b0;

  // DUT B: one header byte, no timestamp
  logic       b_reset = 1'b1;
  logic       b_spi_stb = 1'b0, b_spi_cmd = 1'b0;
  logic [7:0] b_spi_data = 8'h00;
  logic       b_user_ready;
  logic [7:0] b_uart_txd;
  logic       b_uart_stb;
  logic [7:0] b_drop;

  spi_log_arbiter u_dut_a (
    .clk(clk), .reset(a_reset), .log_enable(a_log_enable),
    .spi_rx_strobe(a_spi_stb), .spi_rx_cmd(a_spi_cmd), .spi_rx_data(a_spi_data),
    .user_txd_strobe(a_user_stb), .user_txd_data(a_user_data), .user_txd_ready(a_user_ready),
    .uart_txd(a_uart_txd), .uart_txd_strobe(a_uart_stb), .uart_txd_ready(a_uart_ready),
    .drop_count(a_drop), .drop_clear(a_drop_clear)
  );

  spi_log_arbiter #(.HDR_BYTES(1), .TS_BITS(0)) u_dut_b (
    .clk(clk), .reset(b_reset), .log_enable(1'b1),
    .spi_rx_strobe(b_spi_stb), .spi_rx_cmd(b_spi_cmd), .spi_rx_data(b_spi_data),
    .user_txd_strobe(1'b0), .user_txd_data(8'h00), .user_txd_ready(b_user_ready),
    .uart_txd(b_uart_txd), .uart_txd_strobe(b_uart_stb), .uart_txd_ready(1'b1),
    .drop_count(b_drop), .drop_clear(1'b0)
  );

  // Reference timestamp: counts clk cycles since DUT A's reset
  logic [15:0] ts_model = 16'h0000;
  always @(posedge clk) ts_model <= a_reset ? 16'h0000 : ts_model + 16'h0001;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_uart_stb === 1'b1) begin
      check("a_strobe_needs_ready", 32'(a_uart_ready), 32'd1);
      if (exp_a.size() == 0) check("a_unexpected_strobe", 32'(a_uart_txd), 32'h100);
      else check("a_uart_byte", 32'(a_uart_txd), 32'(exp_a.pop_front()));
    end
    if (b_uart_stb === 1'b1) begin
      if (exp_b.size() == 0) check("b_unexpected_strobe", 32'(b_uart_txd), 32'h100);
      else check("b_uart_byte", 32'(b_uart_txd), 32'(exp_b.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic spi_a(input logic cmd, input logic [7:0] d);
    a_spi_stb = 1'b1; a_spi_cmd = cmd; a_spi_data = d;
    @(posedge clk); #1;
    a_spi_stb = 1'b0; a_spi_cmd = 1'b0;
  endtask

  task automatic spi_b(input logic cmd, input logic [7:0] d);
    b_spi_stb = 1'b1; b_spi_cmd = cmd; b_spi_data = d;
    @(posedge clk); #1;
    b_spi_stb = 1'b0; b_spi_cmd = 1'b0;
  endtask

  task automatic user_a(input logic [7:0] d);
    a_user_stb = 1'b1; a_user_data = d;
    @(posedge clk); #1;
    a_user_stb = 1'b0;
  endtask

  // Push a full record for DUT A using the timestamp of the current cycle,
  // then drive its cmd and data bytes.
  task automatic rec_a(input logic [7:0] c, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [7:0] d3);
    exp_a.push_back(ts_model[15:8]); exp_a.push_back(ts_model[7:0]);
    exp_a.push_back(c); exp_a.push_back(d1); exp_a.push_back(d2); exp_a.push_back(d3);
    spi_a(1'b1, c); spi_a(1'b0, d1); spi_a(1'b0, d2); spi_a(1'b0, d3);
  endtask

  task automatic drain(input bit sel_b, input string tag);
    int n;
    for (int i = 0; i < 60; i++) begin
      n = sel_b ? exp_b.size() : exp_a.size();
      if (n == 0) break;
      @(posedge clk); #2;
    end
    n = sel_b ? exp_b.size() : exp_a.size();
    check(tag, 32'(n), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int guard;
    logic [15:0] tsv;

    repeat (2) @(posedge clk);
    #1;
    check("a_reset_uart_txd", 32'(a_uart_txd), 32'h00);
    check("a_reset_strobe", 32'(a_uart_stb), 32'd0);
    check("a_reset_drop", 32'(a_drop), 32'd0);
    check("a_reset_user_ready", 32'(a_user_ready), 32'd1);
    check("b_reset_user_ready", 32'(b_user_ready), 32'd1);
    a_reset = 1'b0; b_reset = 1'b0;

    // 1: timestamped record, counter 0x1234 at the cmd cycle
    guard = 0;
    while (ts_model != 16'h1234 && guard < 70000) begin
      @(posedge clk); #1; guard++;
    end
    check("ts_reach_1234", 32'(ts_model), 32'h1234);
    exp_a.push_back(8'h12); exp_a.push_back(8'h34); exp_a.push_back(8'h03);
    exp_a.push_back(8'h01); exp_a.push_back(8'h02); exp_a.push_back(8'h03);
    spi_a(1'b1, 8'h03); spi_a(1'b0, 8'h01); spi_a(1'b0, 8'h02); spi_a(1'b0, 8'h03);
    repeat (5) @(posedge clk);
    #2;
    check("rec1_burst_5", 32'(exp_a.size()), 32'd1);
    @(posedge clk); #2;
    check("rec1_burst_6", 32'(exp_a.size()), 32'd0);
    check("rec1_drop", 32'(a_drop), 32'd0);

    // 2: all-zero header filtered; user byte goes out right after
    spi_a(1'b1, 8'h00); spi_a(1'b0, 8'h00); spi_a(1'b0, 8'h00); spi_a(1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    exp_a.push_back(8'h41);
    user_a(8'h41);
    @(posedge clk); #2;
    check("user_41_immediate", 32'(exp_a.size()), 32'd0);
    check("user_41_hold", 32'(a_uart_txd), 32'h41);

    // 3: cmd 0x0B while the record emits with toggling ready -> dropped
    rec_a(8'h07, 8'hA1, 8'hA2, 8'hA3);
    for (int i = 0; i < 10; i++) begin
      a_uart_ready = (i % 2 == 0);
      if (i == 1) begin a_spi_stb = 1'b1; a_spi_cmd = 1'b1; a_spi_data = 8'h0B; end
      if (i >= 2 && i <= 4) begin a_spi_stb = 1'b1; a_spi_cmd = 1'b0; a_spi_data = 8'h0C; end
      @(posedge clk); #1;
      a_spi_stb = 1'b0; a_spi_cmd = 1'b0;
    end
    a_uart_ready = 1'b1;
    drain(1'b0, "rec_toggle_drain");
    check("drop_after_busy", 32'(a_drop), 32'd1);
    a_drop_clear = 1'b1; @(posedge clk); #1; a_drop_clear = 1'b0;
    check("drop_cleared", 32'(a_drop), 32'd0);

    // 4: short transaction discarded silently
    spi_a(1'b1, 8'h03); spi_a(1'b0, 8'h01);
    rec_a(8'h05, 8'hAA, 8'hBB, 8'hCC);
    drain(1'b0, "short_txn_drain");
    check("short_txn_drop", 32'(a_drop), 32'd0);

    // 5: user byte arrives with the last header byte -> record first
    tsv = ts_model;
    exp_a.push_back(tsv[15:8]); exp_a.push_back(tsv[7:0]);
    exp_a.push_back(8'h11); exp_a.push_back(8'h22); exp_a.push_back(8'h33);
    exp_a.push_back(8'h44); exp_a.push_back(8'h55);
    spi_a(1'b1, 8'h11); spi_a(1'b0, 8'h22); spi_a(1'b0, 8'h33);
    a_user_stb = 1'b1; a_user_data = 8'h55;
    spi_a(1'b0, 8'h44);
    a_user_stb = 1'b0;
    check("user_ready_low", 32'(a_user_ready), 32'd0);
    @(posedge clk); #1;
    user_a(8'h66);
    check("user_ready_still_low", 32'(a_user_ready), 32'd0);
    drain(1'b0, "rec_then_user_drain");
    check("user_ready_after", 32'(a_user_ready), 32'd1);

    // 6: drop counter saturation and clear priority
    a_uart_ready = 1'b0;
    a_spi_stb = 1'b1; a_spi_cmd = 1'b1; a_spi_data = 8'h01;
    repeat (260) @(posedge clk);
    #1;
    check("drop_saturate", 32'(a_drop), 32'd255);
    a_drop_clear = 1'b1;
    @(posedge clk); #1;
    a_drop_clear = 1'b0;
    check("drop_clear_priority", 32'(a_drop), 32'd0);
    a_log_enable = 1'b0;
    @(posedge clk); #1;
    a_spi_stb = 1'b0; a_spi_cmd = 1'b0;
    check("drop_log_disabled", 32'(a_drop), 32'd0);
    a_log_enable = 1'b1;
    a_uart_ready = 1'b1;

    // 7: reset in the middle of a record
    rec_a(8'h21, 8'h22, 8'h23, 8'h24);
    a_user_stb = 1'b1; a_user_data = 8'h77;
    @(posedge clk); #1;
    a_user_stb = 1'b0;
    check("user_pending_pre_reset", 32'(a_user_ready), 32'd0);
    @(posedge clk); #1;
    a_reset = 1'b1;
    exp_a.delete();
    @(posedge clk); #1;
    a_reset = 1'b0;
    check("mid_reset_user_ready", 32'(a_user_ready), 32'd1);
    check("mid_reset_uart_txd", 32'(a_uart_txd), 32'h00);
    check("mid_reset_strobe", 32'(a_uart_stb), 32'd0);
    repeat (10) @(posedge clk);
    #2;
    check("mid_reset_quiet", 32'(exp_a.size()), 32'd0);

    // 8: DUT B, single-byte records without timestamp
    exp_b.push_back(8'h9F);
    spi_b(1'b1, 8'h9F);
    drain(1'b1, "b_single_byte");
    check("b_txd_hold", 32'(b_uart_txd), 32'h9F);
    spi_b(1'b1, 8'h00);
    spi_b(1'b0, 8'hEE);
    repeat (4) @(posedge clk);
    #2;
    check("b_zero_filtered", 32'(exp_b.size()), 32'd0);
    check("b_drop", 32'(b_drop), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
